adc_scan_sequencer: RTL and testbench
=====================================

Name: adc_scan_sequencer

Overview:
- Sequencer owning the shared ADC0809-style converter. Round-robins its 8-bit conversions across up to 4 analog channels and drives the ale/start/eoc/oe handshake.
- Keeps a latest-sample register and a running-maximum register per channel.
- Sits between the ADC pins and the binary-to-decimal conversion/LCD path. Its packed outputs feed the per-channel display digits.

Parameters:
- CLK_DIV, 25, clock cycles per adc_clock half-period (adc_clock = clock/(2*CLK_DIV)); legal range ≥ 1.
- SETUP_CYC, 4, clock cycles each handshake phase (SELECT, LATCH, START, READ) is held; ≥ 1.
- EOC_TIMEOUT, 20000, clock cycles allowed in each eoc wait state before abort.
- NUM_CH, 4, number of scanned channels; fixed at 4 in this revision.

Ports:
- clock  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- eoc  in  1  ADC end-of-conversion; asynchronous, synchronised internally.
- adc_data  in  8  ADC tri-state data bus; valid while oe=1.
- chan_en  in  4  channel enable mask; bit i enables channel i.
- max_clr  in  1  single-cycle pulse; clears all four max registers.
- adc_clock  out  1  divided conversion clock to the ADC.
- address  out  3  ADC mux address; bit 2 is always 0.
- ale  out  1  address latch enable.
- start  out  1  conversion start.
- oe  out  1  ADC output enable.
- sample_valid  out  1  one-cycle pulse when a sample is committed.
- sample_chan  out  2  channel of the committed sample.
- sample_data  out  8  committed sample value.
- out_reg  out  32  latest samples; channel i occupies [8i+7:8i].
- out_max  out  32  running maxima, same packing as out_reg.
- timeout_err  out  1  sticky; set on any eoc timeout; cleared only by reset.

Behaviour:
- Reset: every output and register is 0. That includes adc_clock, address, out_reg, out_max and timeout_err. FSM goes to IDLE; scan pointer is set so the next selected channel is the lowest enabled one. A reset mid-conversion abandons it and drops ale/start/oe that same edge.
- adc_clock: free-running toggle every CLK_DIV cycles, independent of FSM state.
- eoc passes through a 2-flop synchroniser. All eoc decisions use the synchronised value, adding 2 cycles of latency.
- IDLE: if chan_en == 0, stay in IDLE. Otherwise pick the next enabled channel after the last serviced one (wrap 3→0) and go to SELECT. chan_en is sampled only here.
- SELECT: address = channel; hold SETUP_CYC cycles.
- LATCH: ale = 1 for SETUP_CYC cycles.
- START: ale = 1 and start = 1 for SETUP_CYC cycles. Both drop together on exit.
- WAIT_LO: wait for synchronised eoc = 0.
- WAIT_HI: wait for synchronised eoc = 1.
- READ: oe = 1 for SETUP_CYC cycles. adc_data is captured on the last oe cycle.
- COMMIT: one cycle.
  - out_reg[ch] <= data.
  - If data > out_max[ch] (unsigned), out_max[ch] <= data.
  - sample_valid = 1, with sample_chan and sample_data presented the same cycle.
  - Then go to IDLE.
- Timeout: a single counter is cleared on entry to WAIT_LO and again on entry to WAIT_HI. Reaching EOC_TIMEOUT-1 in either state:
  - sets timeout_err;
  - goes to IDLE and advances the pointer;
  - issues no COMMIT and makes no register update.
- max_clr:
  - All out_max become 0 on the following edge.
  - If it coincides with COMMIT, the clear wins for out_max, the sample is not merged, and out_reg still updates.
- address stays stable from SELECT until the next SELECT.
- ale, start and oe are never asserted outside their states; oe and start are never high together.
- Nominal commit latency from leaving IDLE: 4*SETUP_CYC + eoc wait time + 2 synchroniser cycles + 1.

Decomposition:
- Package adc_seq_pkg holds:
  - state enum {IDLE, SELECT, LATCH, START, WAIT_LO, WAIT_HI, READ, COMMIT};
  - NUM_CH and the channel index width;
  - the byte-lane slice helper for out_reg/out_max.
- Sub-module adc_clk_div: CLK_DIV counter with toggle flop generating adc_clock.
- The synchroniser, FSM and register bank stay in the top of this block.

Test Plan:
- chan_en=4'b1111; ADC model with eoc low 8 adc_clocks after start, then high; data 8'h10 + channel → commits on channels 0,1,2,3,0 in order, out_reg = 32'h13121110, exactly one sample_valid per commit.
- chan_en=4'b0101 → address sequence 0,2,0,2; channels 1 and 3 of out_reg/out_max stay 0.
- Channel 0 samples 8'h40, 8'h80, 8'h20 → out_max[7:0] = 8'h80, out_reg[7:0] = 8'h20.
- eoc held high forever with EOC_TIMEOUT=100 → timeout_err=1 at cycle 99 of WAIT_LO, no sample_valid, next channel selected.
- max_clr asserted on the COMMIT cycle with data 8'hFF → out_max lane = 0 and out_reg lane = 8'hFF.
- reset asserted during READ → next edge has oe=0, all outputs 0, FSM in IDLE; scanning restarts at channel 0.

Source files
------------

// File: rtl/adc_seq_pkg.sv
// Shared types and helpers for the ADC scan sequencer: FSM states, channel count,
// round-robin pick and byte-lane access into the packed per-channel registers.
package adc_seq_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = $clog2(NUM_CH);

    typedef enum logic [2:0] {
        IDLE, SELECT, LATCH, START, WAIT_LO, WAIT_HI, READ, COMMIT
    } state_t;

    function automatic logic [4:0] lane_lsb(input logic [CH_W-1:0] ch);
        return {ch, 3'b000};
    endfunction

    function automatic logic [7:0] lane_get(input logic [NUM_CH*8-1:0] v,
                                            input logic [CH_W-1:0] ch);
        return v[lane_lsb(ch) +: 8];
    endfunction

    // First enabled channel at or after ptr, wrapping; scanned high-to-low so the
    // smallest offset is the one left standing.
    function automatic logic [CH_W-1:0] next_chan(input logic [NUM_CH-1:0] en,
                                                  input logic [CH_W-1:0] ptr);
        logic [CH_W-1:0] pick;
        pick = ptr;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (en[ptr + CH_W'(i)]) pick = ptr + CH_W'(i);
        end
        return pick;
    endfunction

endpackage

// File: rtl/adc_clk_div.sv
// Free-running divider: adc_clock toggles every CLK_DIV clock cycles.
// Output registered; first toggle CLK_DIV cycles after reset; no backpressure.
module adc_clk_div #(
    parameter int CLK_DIV = 25
) (
    input  logic clock,
    input  logic reset,
    output logic adc_clock
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt       <= '0;
            adc_clock <= 1'b0;
        end else if (cnt == LAST) begin
            cnt       <= '0;
            adc_clock <= ~adc_clock;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Round-robin ADC0809 scan: drives ale/start/oe handshake, keeps latest and max per channel.
// Commit 4*SETUP_CYC + eoc wait + 3 cycles after leaving IDLE; no backpressure, eoc waits time out.
module adc_scan_sequencer
    import adc_seq_pkg::*;
#(
    parameter int CLK_DIV     = 25,
    parameter int SETUP_CYC   = 4,
    parameter int EOC_TIMEOUT = 20000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                eoc,
    input  logic [7:0]          adc_data,
    input  logic [NUM_CH-1:0]   chan_en,
    input  logic                max_clr,
    output logic                adc_clock,
    output logic [2:0]          address,
    output logic                ale,
    output logic                start,
    output logic                oe,
    output logic                sample_valid,
    output logic [CH_W-1:0]     sample_chan,
    output logic [7:0]          sample_data,
    output logic [NUM_CH*8-1:0] out_reg,
    output logic [NUM_CH*8-1:0] out_max,
    output logic                timeout_err
);

    localparam int SCW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
    localparam int TCW = (EOC_TIMEOUT > 1) ? $clog2(EOC_TIMEOUT) : 1;
    localparam logic [SCW-1:0] SC_LAST = SCW'(SETUP_CYC - 1);
    localparam logic [TCW-1:0] TO_LAST = TCW'(EOC_TIMEOUT - 1);

    state_t          state;
    logic            eoc_meta;
    logic            eoc_sync;
    logic [SCW-1:0]  phase_cnt;
    logic [TCW-1:0]  wait_cnt;
    logic [CH_W-1:0] ch;
    logic [CH_W-1:0] ptr;
    logic [CH_W-1:0] nxt_ch;
    logic            phase_done;

    assign nxt_ch     = next_chan(chan_en, ptr);
    assign phase_done = (phase_cnt == SC_LAST);

    adc_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clock     (clock),
        .reset     (reset),
        .adc_clock (adc_clock)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            eoc_meta     <= 1'b0;
            eoc_sync     <= 1'b0;
            phase_cnt    <= '0;
            wait_cnt     <= '0;
            ch           <= '0;
            ptr          <= '0;
            address      <= '0;
            ale          <= 1'b0;
            start        <= 1'b0;
            oe           <= 1'b0;
            sample_valid <= 1'b0;
            sample_chan  <= '0;
            sample_data  <= '0;
            out_reg      <= '0;
            out_max      <= '0;
            timeout_err  <= 1'b0;
        end else begin
            eoc_meta     <= eoc;
            eoc_sync     <= eoc_meta;
            sample_valid <= 1'b0;
            if (max_clr) out_max <= '0;

            case (state)
                IDLE: begin
                    if (chan_en != '0) begin
                        ch        <= nxt_ch;
                        address   <= {1'b0, nxt_ch};
                        phase_cnt <= '0;
                        state     <= SELECT;
                    end
                end
                SELECT: begin
                    if (phase_done) begin
                        phase_cnt <= '0;
                        ale       <= 1'b1;
                        state     <= LATCH;
                    end else begin
                        phase_cnt <= phase_cnt + SCW'(1);
                    end
                end
                LATCH: begin
                    if (phase_done) begin
                        phase_cnt <= '0;
                        start     <= 1'b1;
                        state     <= START;
                    end else begin
                        phase_cnt <= phase_cnt + SCW'(1);
                    end
                end
                START: begin
                    if (phase_done) begin
                        phase_cnt <= '0;
                        ale       <= 1'b0;
                        start     <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= WAIT_LO;
                    end else begin
                        phase_cnt <= phase_cnt + SCW'(1);
                    end
                end
                WAIT_LO: begin
                    if (!eoc_sync) begin
                        wait_cnt <= '0;
                        state    <= WAIT_HI;
                    end else if (wait_cnt == TO_LAST) begin
                        timeout_err <= 1'b1;
                        ptr         <= ch + CH_W'(1);
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + TCW'(1);
                    end
                end
                WAIT_HI: begin
                    if (eoc_sync) begin
                        phase_cnt <= '0;
                        oe        <= 1'b1;
                        state     <= READ;
                    end else if (wait_cnt == TO_LAST) begin
                        timeout_err <= 1'b1;
                        ptr         <= ch + CH_W'(1);
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + TCW'(1);
                    end
                end
                READ: begin
                    if (phase_done) begin
                        oe           <= 1'b0;
                        sample_valid <= 1'b1;
                        sample_chan  <= ch;
                        sample_data  <= adc_data;
                        state        <= COMMIT;
                    end else begin
                        phase_cnt <= phase_cnt + SCW'(1);
                    end
                end
                COMMIT: begin
                    out_reg[lane_lsb(ch) +: 8] <= sample_data;
                    // A coincident max_clr leaves the whole max bank cleared.
                    if (!max_clr && (sample_data > lane_get(out_max, ch)))
                        out_max[lane_lsb(ch) +: 8] <= sample_data;
                    ptr   <= ch + CH_W'(1);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
`timescale 1ns/1ps
module tb_adc_scan_sequencer;

    localparam int CLK_DIV     = 2;
    localparam int SETUP_CYC   = 2;
    localparam int EOC_TIMEOUT = 100;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        eoc = 1'b1;
    logic [7:0]  adc_data = 8'h00;
    logic [3:0]  chan_en = 4'h0;
    logic        max_clr = 1'b0;
    logic        adc_clock, ale, start, oe, sample_valid, timeout_err;
    logic [2:0]  address;
    logic [1:0]  sample_chan;
    logic [7:0]  sample_data;
    logic [31:0] out_reg, out_max;

    adc_scan_sequencer #(
        .CLK_DIV(CLK_DIV), .SETUP_CYC(SETUP_CYC), .EOC_TIMEOUT(EOC_TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset), .eoc(eoc), .adc_data(adc_data),
        .chan_en(chan_en), .max_clr(max_clr), .adc_clock(adc_clock),
        .address(address), .ale(ale), .start(start), .oe(oe),
        .sample_valid(sample_valid), .sample_chan(sample_chan),
        .sample_data(sample_data), .out_reg(out_reg), .out_max(out_max),
        .timeout_err(timeout_err)
    );

    initial forever #5 clock = ~clock;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc = 0;
    int commit_cnt = 0;
    int data_mode = 0;   // 0 random, 1 8'h10+ch, 2 table, 3 8'hFF
    bit stuck = 1'b0;    // ADC never pulls eoc low
    logic [1:0] addr_log [$];
    logic [1:0] chan_log [$];
    logic [7:0] seq_data [3] = '{8'h40, 8'h80, 8'h20};

    // Reference model state
    logic [7:0] m_reg [4];
    logic [7:0] m_max [4];
    bit         m_to, pending, prev_reset, p_ale, p_start, p_oe;
    logic [1:0] m_ptr, pend_ch;
    logic [7:0] conv;
    int to_at, lo_at, hi_at, hi_drv, ale_cyc, st_cyc, oe_n, n_adc, conv_idx;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] next_en(input logic [1:0] p, input logic [3:0] en);
        for (int k = 0; k < 4; k++)
            if (en[(p + k) % 4]) return 2'((p + k) % 4);
        return p;
    endfunction

    // ADC behavioural model plus per-cycle compare against the reference model.
    initial begin
        prev_reset = 1'b1;
        forever begin
            @(negedge clock);
            cyc++;
            if (prev_reset) begin
                for (int i = 0; i < 4; i++) begin m_reg[i] = 8'h00; m_max[i] = 8'h00; end
                m_to = 1'b0; pending = 1'b0; m_ptr = 2'd0; pend_ch = 2'd0;
                to_at = -1; lo_at = -1; hi_at = -1; hi_drv = -1000;
                oe_n = 0; n_adc = 0; conv_idx = 0; conv = 8'h00;
                eoc = 1'b1;
                check("reset_ctrl", {adc_clock, address, ale, start, oe, sample_valid,
                                     sample_chan, sample_data, timeout_err}, 32'h0);
                check("reset_regs", out_reg | out_max, 32'h0);
            end else begin
                n_adc++;
                if (cyc == to_at) m_to = 1'b1;
                check("adc_clock", adc_clock, ((n_adc / CLK_DIV) % 2));
                check("out_reg", out_reg, {m_reg[3], m_reg[2], m_reg[1], m_reg[0]});
                check("out_max", out_max, {m_max[3], m_max[2], m_max[1], m_max[0]});
                check("timeout_err", timeout_err, m_to);
                check("oe_excl", (oe && start) || (oe && ale), 1'b0);
                check("addr_bit2", address[2], 1'b0);

                if (ale && !p_ale) begin
                    if (pending) begin
                        if (!stuck) check("missed_commit", pending, 1'b0);
                        m_ptr = pend_ch + 2'd1;
                    end
                    check("ale_with_no_chan", (chan_en == 4'h0), 1'b0);
                    pend_ch = next_en(m_ptr, chan_en);
                    check("select_addr", address, {1'b0, pend_ch});
                    pending = 1'b1;
                    ale_cyc = cyc;
                    addr_log.push_back(address[1:0]);
                    case (data_mode)
                        1: conv = 8'h10 + 8'(pend_ch);
                        2: conv = seq_data[conv_idx % 3];
                        3: conv = 8'hFF;
                        default: conv = 8'($urandom_range(0, 255));
                    endcase
                    conv_idx++;
                end
                if (start && !p_start) begin
                    check("latch_len", cyc - ale_cyc, SETUP_CYC);
                    st_cyc = cyc;
                    if (!stuck) begin
                        lo_at = cyc + $urandom_range(1, 3);
                        hi_at = lo_at + 8 * 2 * CLK_DIV + $urandom_range(0, 20);
                    end
                end
                if (!start && p_start) begin
                    check("start_len", cyc - st_cyc, SETUP_CYC);
                    check("ale_drop", ale, 1'b0);
                    if (stuck) to_at = cyc + EOC_TIMEOUT;
                end
                if (oe) oe_n++;
                else if (p_oe) begin
                    check("oe_len", oe_n, SETUP_CYC);
                    oe_n = 0;
                end

                if (sample_valid) begin
                    check("unexpected_commit", pending, 1'b1);
                    check("sample_chan", sample_chan, pend_ch);
                    check("sample_data", sample_data, conv);
                    check("eoc_to_commit", cyc - hi_drv, 3 + SETUP_CYC);
                    m_reg[sample_chan] = sample_data;
                    if (max_clr)
                        for (int i = 0; i < 4; i++) m_max[i] = 8'h00;
                    else if (conv > m_max[pend_ch])
                        m_max[pend_ch] = conv;
                    m_ptr = pend_ch + 2'd1;
                    pending = 1'b0;
                    commit_cnt++;
                    chan_log.push_back(sample_chan);
                end else if (max_clr) begin
                    for (int i = 0; i < 4; i++) m_max[i] = 8'h00;
                end

                if (cyc == lo_at) eoc = 1'b0;
                if (cyc == hi_at) begin eoc = 1'b1; hi_drv = cyc; end
                adc_data = (oe && oe_n == SETUP_CYC) ? conv : ~conv;
            end
            p_ale = ale; p_start = start; p_oe = oe;
            prev_reset = reset;
        end
    end

    task automatic do_reset(input logic [3:0] en, input int mode, input bit stk);
        @(posedge clock); #1;
        reset = 1'b1; chan_en = en; data_mode = mode; stuck = stk; max_clr = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic wait_commits(input int target, input int budget, input string nm);
        int k = 0;
        while (commit_cnt < target && k < budget) begin @(posedge clock); #1; k++; end
        check(nm, (commit_cnt >= target), 1'b1);
    endtask

    task automatic wait_ales(input int target, input int budget, input string nm);
        int k = 0;
        while (addr_log.size() < target && k < budget) begin @(posedge clock); #1; k++; end
        check(nm, (addr_log.size() >= target), 1'b1);
    endtask

    logic [1:0] ord [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0] alt [4] = '{2'd0, 2'd2, 2'd0, 2'd2};

    initial begin
        int b, bc, ba, k;
        logic [3:0] en;

        // All four channels, data 8'h10+ch
        do_reset(4'b1111, 1, 1'b0);
        b = commit_cnt; bc = chan_log.size();
        wait_commits(b + 5, 800, "p1_commits");
        check("p1_out_reg", out_reg, 32'h13121110);
        check("p1_out_max", out_max, 32'h13121110);
        for (int i = 0; i < 5; i++)
            if (chan_log.size() > bc + i) check("p1_order", chan_log[bc + i], ord[i]);

        // Sparse mask skips channels 1 and 3
        do_reset(4'b0101, 0, 1'b0);
        ba = addr_log.size();
        wait_ales(ba + 4, 800, "p2_selects");
        for (int i = 0; i < 4; i++)
            if (addr_log.size() > ba + i) check("p2_addr_seq", addr_log[ba + i], alt[i]);
        check("p2_reg_idle_lanes", out_reg & 32'hFF00FF00, 32'h0);
        check("p2_max_idle_lanes", out_max & 32'hFF00FF00, 32'h0);

        // Running maximum on channel 0
        do_reset(4'b0001, 2, 1'b0);
        b = commit_cnt;
        wait_commits(b + 3, 600, "p3_commits");
        check("p3_max_lane0", out_max[7:0], 8'h80);
        check("p3_reg_lane0", out_reg[7:0], 8'h20);

        // eoc never falls: timeout, no commit, pointer advances
        do_reset(4'b1111, 0, 1'b1);
        b = commit_cnt; ba = addr_log.size();
        k = 0;
        while (!timeout_err && k < 400) begin @(posedge clock); #1; k++; end
        check("p4_timeout_err", timeout_err, 1'b1);
        check("p4_no_commit", commit_cnt - b, 0);
        wait_ales(ba + 2, 400, "p4_reselect");
        if (addr_log.size() > ba + 1) check("p4_next_chan", addr_log[ba + 1], 2'd1);

        // max_clr coinciding with COMMIT
        do_reset(4'b0001, 3, 1'b0);
        k = 0;
        while (!sample_valid && k < 400) begin @(posedge clock); #1; k++; end
        check("p5_commit_seen", sample_valid, 1'b1);
        max_clr = 1'b1;
        @(posedge clock); #1;
        max_clr = 1'b0;
        check("p5_max_cleared", out_max[7:0], 8'h00);
        check("p5_reg_kept", out_reg[7:0], 8'hFF);

        // Reset during READ restarts the scan at channel 0
        do_reset(4'b1111, 0, 1'b0);
        b = commit_cnt;
        wait_commits(b + 2, 600, "p6_commits");
        k = 0;
        while (!oe && k < 400) begin @(posedge clock); #1; k++; end
        check("p6_in_read", oe, 1'b1);
        reset = 1'b1;
        @(posedge clock); #1;
        check("p6_oe_dropped", {oe, ale, start}, 3'b000);
        reset = 1'b0;
        ba = addr_log.size();
        wait_ales(ba + 1, 200, "p6_restart");
        if (addr_log.size() > ba) check("p6_restart_chan", addr_log[ba], 2'd0);

        // Random masks, data and max_clr pulses
        for (int it = 0; it < 6; it++) begin
            en = (it == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            do_reset(en, 0, 1'b0);
            b = commit_cnt; ba = addr_log.size();
            repeat (500) begin
                @(posedge clock); #1;
                max_clr = ($urandom_range(0, 50) == 0);
            end
            max_clr = 1'b0;
            if (en == 4'h0) check("p7_idle_no_select", addr_log.size() - ba, 0);
            else            check("p7_progress", (commit_cnt - b >= 5), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
